rr_arb32: RTL and testbench
===========================

RR_ARB32 -- requirements
Module: rr_arb32

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 16, giving the maximum number of GRANT cycles per grant (0 = unlimited).
REQ-002 SHALL have parameter CNT_W, default 8, giving the hold-counter width; HOLD_MAX SHALL be at most 2^CNT_W-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req, input, 32 bits: request line i is req[i], level, held until served.
REQ-006 SHALL have port done, input, 1 bit: one-cycle pulse from the current owner releasing the grant.
REQ-007 SHALL have port gnt, output, 32 bits: one-hot grant, zero when no owner.
REQ-008 SHALL have port sel, output, 5 bits: binary index of the owner, drives the 5-bit select of the 32:1 operand mux.
REQ-009 SHALL have port valid, output, 1 bit: high while gnt is nonzero (mux output meaningful).
REQ-010 SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is force-released by HOLD_MAX.

Function
REQ-011 SHALL implement two states: IDLE and GRANT.
REQ-012 SHALL keep a 5-bit round-robin pointer ptr; priority order is ptr, ptr+1, ..., 31, 0, ..., ptr-1.
REQ-013 In IDLE with req nonzero, SHALL select the first set req bit in that order, then in the next cycle: state=GRANT, sel=index, gnt=1<<index, valid=1, hold count=0.
REQ-014 In IDLE with req zero, SHALL hold gnt=0, valid=0, and sel at its last value.
REQ-015 Grant latency SHALL be exactly 1 cycle from the sampled req to the asserted gnt.
REQ-016 In GRANT, the grant SHALL be released when any of these holds: done=1; req[sel]=0; or HOLD_MAX!=0 and the count reaches HOLD_MAX-1.
REQ-017 On release, next cycle: state=IDLE, gnt=0, valid=0, ptr=(sel+1) mod 32 (31 wraps to 0).
REQ-018 There SHALL be at least one IDLE cycle between consecutive grants (no back-to-back overlap).
REQ-019 valid SHALL stay high for exactly HOLD_MAX cycles when a grant is force-released.
REQ-020 timeout SHALL pulse high for exactly the one cycle in which gnt drops due to HOLD_MAX.
REQ-021 If done, or req[sel] dropping, coincides with the HOLD_MAX limit, the release SHALL count as normal and timeout SHALL stay 0.
REQ-022 Requests from non-owners during GRANT SHALL be ignored until the next IDLE evaluation.
REQ-023 The hold counter SHALL saturate and never wrap while in GRANT.
REQ-024 done while in IDLE SHALL be ignored.
REQ-025 sel SHALL change only on entry to GRANT.

Reset
REQ-026 rst high at a clock edge SHALL set state=IDLE, ptr=0, count=0, gnt=0, sel=0, valid=0, timeout=0 on the next cycle, including mid-grant.
REQ-027 The first arbitration after reset SHALL favour req[0].

Structure
REQ-028 State encodings (IDLE=0, GRANT=1) and NUM_REQ=32 SHALL live in a shared arbiter-constants include file.
REQ-029 Rotated priority selection SHALL be a sub-module pri_enc32 (req, ptr -> found, index), purely combinational.
REQ-030 All registers SHALL be in one clocked block, and next-state logic SHALL be separate combinational logic.

Verification
REQ-031 Reset, then req=32'h0000_0001 -> one cycle later gnt=32'h1, sel=0, valid=1; after done, gnt=0 and ptr=1.
REQ-032 req=32'hFFFF_FFFF held, done one cycle after each grant -> sel sequence 0,1,2,...,31,0 with a one-cycle IDLE gap between grants.
REQ-033 Owner 31 released, then req=32'h4000_0001 -> sel=0 (wrap), then sel=30.
REQ-034 HOLD_MAX=16, req[5] held, no done -> valid high 16 cycles, timeout=1 for one cycle as gnt drops, then req[5] alone is regranted with sel=5.
REQ-035 done asserted in the same cycle as the HOLD_MAX limit -> gnt drops and timeout stays 0.
REQ-036 rst during GRANT with sel=12 -> next cycle gnt=0, valid=0, sel=0; with req=32'h0000_1001, the next grant is sel=0.

Source files
------------

// File: rtl/rr_arb32_pkg.sv
// Shared arbiter constants: requester count, index width and FSM state encoding.
package rr_arb32_pkg;

  // Number of requesters and the width of a binary requester index.
  localparam int NUM_REQ = 32;
  localparam int IDX_W   = 5;

  // Arbiter FSM: IDLE evaluates requests, GRANT holds one owner.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // One-hot vector with only bit 0 set; shifted by an index to form a grant.
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

endpackage

// File: rtl/rr_arb32_pri_enc32.sv
// Rotated priority encoder: finds the first set request starting at ptr and
// wrapping through 31 back to ptr-1. Purely combinational.
module pri_enc32
  import rr_arb32_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  // Rotating the request vector right by ptr puts the highest-priority line
  // at bit 0, so a plain lowest-set-bit search gives the offset from ptr.
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     off;

  // Rotate, search for the lowest set bit, then add the offset back to ptr.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[NUM_REQ-1:0];
    found = 1'b0;
    off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = IDX_W'(k);
      end
    end
    // Index arithmetic wraps naturally modulo 32 in 5 bits.
    index = ptr + off;
  end

endmodule

// File: rtl/rr_arb32.sv
// 32-way round-robin arbiter with a per-grant hold limit.
//
// Handshake: a requester raises req[i] and keeps it high until served. One
// cycle after an IDLE evaluation finds it, gnt/sel/valid assert and stay
// until the owner pulses done, drops req[sel], or the hold limit expires.
// Every grant is followed by at least one IDLE cycle, and timeout pulses in
// the first IDLE cycle only when the hold limit alone ended the grant.
module rr_arb32
  import rr_arb32_pkg::*;
#(
  parameter int HOLD_MAX = 16, // max GRANT cycles per grant, 0 = unlimited
  parameter int CNT_W    = 8   // hold counter width, HOLD_MAX <= 2^CNT_W-1
)(
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  input  logic                done,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [IDX_W-1:0]    sel,
  output logic                valid,
  output logic                timeout
);

  // Counter value seen in the last permitted GRANT cycle (count starts at 0).
  localparam logic [CNT_W-1:0] HOLD_LIM =
    (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q,   ptr_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [NUM_REQ-1:0]  gnt_q,   gnt_d;
  logic [IDX_W-1:0]    sel_q,   sel_d;
  logic                valid_q, valid_d;
  logic                to_q,    to_d;

  logic                found;
  logic [IDX_W-1:0]    index;
  logic                owner_req;
  logic                limit_hit;
  logic                release_now;

  pri_enc32 u_pri_enc (
    .req   (req),
    .ptr   (ptr_q),
    .found (found),
    .index (index)
  );

  // Release conditions for the current owner; the limit only applies in GRANT
  // and only when a hold limit is configured.
  always_comb begin
    owner_req   = req[sel_q];
    limit_hit   = (HOLD_MAX != 0) && (cnt_q == HOLD_LIM);
    release_now = done || !owner_req || limit_hit;
  end

  // Next-state and next-output logic for the IDLE/GRANT FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // done is meaningless without an owner and is not looked at here.
        if (found) begin
          state_d = GRANT;
          sel_d   = index;
          gnt_d   = ONE_HOT0 << index;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else begin
          gnt_d   = '0;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        // Other requesters are not looked at until the next IDLE evaluation.
        if (release_now) begin
          state_d = IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
          cnt_d   = '0;
          ptr_d   = sel_q + IDX_W'(1);
          // A limit expiry that coincides with a normal release is normal.
          to_d    = limit_hit && !done && owner_req;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // All arbiter registers; synchronous reset clears everything, even mid-grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      to_q    <= to_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign valid   = valid_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_rr_arb32.sv
// Testbench for rr_arb32: directed scenarios plus randomized traffic, checked
// cycle by cycle against an abstract round-robin model through an expected queue.
module tb_rr_arb32;

  localparam int HOLD_MAX = 16;
  localparam int CNT_W    = 8;
  localparam int W        = 39; // {gnt[31:0], sel[4:0], valid, timeout}
  localparam int MON_MAX  = 20000;

  // Clock / reset / DUT
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req;
  logic        done;
  logic [31:0] gnt;
  logic [4:0]  sel;
  logic        valid;
  logic        timeout;

  always #5 clk = ~clk;

  rr_arb32 #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .valid   (valid),
    .timeout (timeout)
  );

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  drv_done = 1'b0;

  // Reference model: owner (-1 when none), round-robin start, cycles the
  // current owner has already had the grant, last reported owner index.
  int  m_owner = -1;
  int  m_ptr   = 0;
  int  m_held  = 0;
  int  m_sel   = 0;
  bit  m_to    = 1'b0;

  // Advance the model by one clock edge and queue the outputs it predicts.
  task automatic model_step(input logic [31:0] r, input logic d, input logic rs);
    bit at_limit;
    bit hit;
    int c;
    logic [31:0] e_gnt;
    m_to = 1'b0;
    if (rs) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_sel   = 0;
    end else if (m_owner < 0) begin
      hit = 1'b0;
      for (int k = 0; k < 32; k++) begin
        c = (m_ptr + k) % 32;
        if (!hit && r[c]) begin
          hit     = 1'b1;
          m_owner = c;
          m_sel   = c;
          m_held  = 1;
        end
      end
    end else begin
      at_limit = (HOLD_MAX != 0) && (m_held == HOLD_MAX);
      if (d || !r[m_owner] || at_limit) begin
        m_to    = at_limit && !d && r[m_owner];
        m_ptr   = (m_owner + 1) % 32;
        m_owner = -1;
        m_held  = 0;
      end else begin
        m_held++;
      end
    end
    e_gnt = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    exp_q.push_back({e_gnt, 5'(m_sel), (m_owner >= 0), m_to});
  endtask

  // Driver: apply one cycle of inputs, predict, then wait for the next negedge.
  task automatic cyc(input logic [31:0] r, input logic d, input logic rs);
    req  = r;
    done = d;
    rst  = rs;
    model_step(r, d, rs);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, expv);
    end
  endtask

  // Directed scenarios followed by randomized traffic.
  task automatic drive_all();
    logic [31:0] r;
    logic        d;
    int          done_pct;
    // Reset
    for (int i = 0; i < 3; i++) cyc(32'h0, 1'b0, 1'b1);
    cyc(32'h0, 1'b1, 1'b0);                 // done in IDLE is ignored
    // Single requester 0, then release with done
    cyc(32'h1, 1'b0, 1'b0);
    cyc(32'h1, 1'b1, 1'b0);
    cyc(32'h0, 1'b0, 1'b0);
    // All requesting: rotation 1..31 then 0, then 1..31 so 31 is last owner
    for (int g = 0; g < 63; g++) begin
      cyc(32'hFFFF_FFFF, 1'b0, 1'b0);
      cyc(32'hFFFF_FFFF, 1'b1, 1'b0);
    end
    // Wrap after owner 31: 0 first, then 30
    cyc(32'h4000_0001, 1'b0, 1'b0);
    cyc(32'h4000_0001, 1'b1, 1'b0);
    cyc(32'h4000_0000, 1'b0, 1'b0);
    cyc(32'h4000_0000, 1'b1, 1'b0);
    cyc(32'h0, 1'b0, 1'b0);
    // Hold limit expiry with req[5] held, then regrant of 5
    for (int i = 0; i < 2 * HOLD_MAX + 6; i++) cyc(32'h20, 1'b0, 1'b0);
    cyc(32'h0, 1'b0, 1'b0);
    cyc(32'h0, 1'b0, 1'b0);
    // done coinciding with the limit: no timeout
    cyc(32'h20, 1'b0, 1'b0);
    for (int i = 0; i < HOLD_MAX - 1; i++) cyc(32'h20, 1'b0, 1'b0);
    cyc(32'h20, 1'b1, 1'b0);
    cyc(32'h0, 1'b0, 1'b0);
    // req drop coinciding with the limit: no timeout
    for (int i = 0; i < HOLD_MAX; i++) cyc(32'h20, 1'b0, 1'b0);
    cyc(32'h0, 1'b0, 1'b0);
    cyc(32'h0, 1'b0, 1'b0);
    // Reset mid-grant with owner 12, then req 0 and 12 favour 0
    cyc(32'h1000, 1'b0, 1'b0);
    cyc(32'h1000, 1'b0, 1'b0);
    cyc(32'h1000, 1'b0, 1'b1);
    cyc(32'h1001, 1'b0, 1'b0);
    cyc(32'h1001, 1'b0, 1'b0);
    cyc(32'h0, 1'b0, 1'b0);
    // Randomized traffic in blocks with different done rates
    r = 32'h0;
    for (int blk = 0; blk < 16; blk++) begin
      done_pct = (blk % 2 == 0) ? 25 : 2;
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 3))
            0:       r = 32'h0;
            1:       r = 32'd1 << $urandom_range(0, 31);
            2:       r = $urandom;
            default: r = $urandom & $urandom & $urandom;
          endcase
        end
        d = ($urandom_range(0, 99) < done_pct);
        cyc(r, d, ($urandom_range(0, 249) == 0));
      end
    end
    cyc(32'h0, 1'b0, 1'b0);
    drv_done = 1'b1;
  endtask

  // Monitor: after each active edge, pop the prediction and compare.
  task automatic monitor();
    logic [W-1:0] e;
    int cycles;
    cycles = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt",     gnt,            e[38:7]);
        check("sel",     32'(sel),       32'(e[6:2]));
        check("valid",   32'(valid),     32'(e[1]));
        check("timeout", 32'(timeout),   32'(e[0]));
      end else if (drv_done) begin
        break;
      end
      cycles++;
      if (cycles > MON_MAX) begin
        n_tests++;
        n_fail++;
        $display("FAIL monitor_budget: ran %0d cycles, expected at most %0d", cycles, MON_MAX);
        break;
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 32'h0;
    done = 1'b0;
    fork
      drive_all();
      monitor();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
